// File: rtl/sobel_pkg.sv
// Shared definitions for the sobel window generator: default geometry, FSM states
// and the per-tap padding masks (bit t of a mask corresponds to tap w<t>).
package sobel_pkg;

  localparam int IMG_W_DEFAULT = 512;
  localparam int IMG_H_DEFAULT = 512;
  localparam int PIX_W_DEFAULT = 8;
  localparam int TAP_W_DEFAULT = 9;

  typedef enum logic [1:0] {FILL, STREAM, FLUSH} state_t;

  localparam int TAP_N      = 9;
  localparam int TAP_CENTRE = 4;

  localparam logic [TAP_N-1:0] MASK_TOP   = 9'b000_000_111;
  localparam logic [TAP_N-1:0] MASK_BOT   = 9'b111_000_000;
  localparam logic [TAP_N-1:0] MASK_LEFT  = 9'b001_001_001;
  localparam logic [TAP_N-1:0] MASK_RIGHT = 9'b100_100_100;

endpackage

// File: rtl/sobel_line_buf.sv
// One-row delay line: dout holds the sample written DEPTH enables earlier.
// The next output is pre-read from the array so the read port stays registered.
module sobel_line_buf #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] ptr_next;
  logic [WIDTH-1:0] dout_reg;

  assign ptr_next = (ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : ptr_reg + 1'b1;
  assign dout     = dout_reg;

  // Array contents are not cleared: stale entries only ever reach taps that
  // the window padding forces to zero.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg  <= '0;
      dout_reg <= '0;
    end else if (en) begin
      ptr_reg  <= ptr_next;
      dout_reg <= mem[ptr_next];
    end
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster pixel stream in, one zero-padded 3x3 neighbourhood per pixel out.
// Window k is built when pixel k+IMG_W+1 arrives (or during the zero-fed flush).
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEFAULT,
  parameter int IMG_H = IMG_H_DEFAULT,
  parameter int PIX_W = PIX_W_DEFAULT,
  parameter int TAP_W = TAP_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAP_W-1:0] w0,
  output logic [TAP_W-1:0] w1,
  output logic [TAP_W-1:0] w2,
  output logic [TAP_W-1:0] w3,
  output logic [TAP_W-1:0] w4,
  output logic [TAP_W-1:0] w5,
  output logic [TAP_W-1:0] w6,
  output logic [TAP_W-1:0] w7,
  output logic [TAP_W-1:0] w8,
  output logic             out_last
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(NPIX);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  state_t           state_reg;
  logic [CNT_W-1:0] in_cnt_reg;
  logic [COL_W-1:0] col_reg;
  logic [ROW_W-1:0] row_reg;
  logic             done_reg;
  logic             out_valid_reg;
  logic             out_last_reg;
  logic [PIX_W-1:0] col_a_reg [3];
  logic [PIX_W-1:0] col_b_reg [3];
  logic [TAP_W-1:0] w_reg     [TAP_N];

  logic             adv;
  logic             accept;
  logic             flush_emit;
  logic             shift;
  logic             emit;
  logic             is_last_win;
  logic [PIX_W-1:0] bot_pix;
  logic [PIX_W-1:0] lb1_dout;
  logic [PIX_W-1:0] lb2_dout;
  logic [PIX_W-1:0] new_col   [3];
  logic [TAP_N-1:0] pad_mask;
  logic [TAP_W-1:0] win_next  [TAP_N];

  assign adv        = !out_valid_reg || out_ready;
  assign in_ready   = !rst && (state_reg != FLUSH) && adv;
  assign accept     = in_valid && in_ready;
  assign flush_emit = !rst && (state_reg == FLUSH) && adv && !done_reg;
  assign shift      = accept || flush_emit;
  assign emit       = flush_emit
                   || (accept && state_reg == STREAM)
                   || (accept && state_reg == FILL && in_cnt_reg == CNT_W'(IMG_W + 1));
  assign is_last_win = (row_reg == ROW_W'(IMG_H - 1)) && (col_reg == COL_W'(IMG_W - 1));

  // During flush the bottom row is fed zeros; the row delay lines keep draining.
  assign bot_pix = (state_reg == FLUSH) ? '0 : in_pixel;

  sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk  (clk),
    .rst  (rst),
    .en   (shift),
    .din  (bot_pix),
    .dout (lb1_dout)
  );

  sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb2 (
    .clk  (clk),
    .rst  (rst),
    .en   (shift),
    .din  (lb1_dout),
    .dout (lb2_dout)
  );

  assign new_col[0] = lb2_dout;
  assign new_col[1] = lb1_dout;
  assign new_col[2] = bot_pix;

  assign pad_mask = ((row_reg == '0)                  ? MASK_TOP   : '0)
                  | ((row_reg == ROW_W'(IMG_H - 1))   ? MASK_BOT   : '0)
                  | ((col_reg == '0)                  ? MASK_LEFT  : '0)
                  | ((col_reg == COL_W'(IMG_W - 1))   ? MASK_RIGHT : '0);

  // Columns: left = col_a, middle = col_b, right = the column arriving now.
  for (genvar gi = 0; gi < TAP_N; gi++) begin : g_tap
    localparam int TROW = gi / 3;
    localparam int TCOL = gi % 3;
    logic [PIX_W-1:0] raw;
    if (TCOL == 0) begin : g_left
      assign raw = col_a_reg[TROW];
    end else if (TCOL == 1) begin : g_mid
      assign raw = col_b_reg[TROW];
    end else begin : g_right
      assign raw = new_col[TROW];
    end
    assign win_next[gi] = pad_mask[gi] ? '0 : TAP_W'(raw);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= FILL;
      in_cnt_reg    <= '0;
      col_reg       <= '0;
      row_reg       <= '0;
      done_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      col_a_reg     <= '{default: '0};
      col_b_reg     <= '{default: '0};
      w_reg         <= '{default: '0};
    end else begin
      if (shift) begin
        col_a_reg <= col_b_reg;
        col_b_reg <= new_col;
      end

      if (emit) begin
        out_valid_reg <= 1'b1;
        out_last_reg  <= is_last_win;
        w_reg         <= win_next;
        if (col_reg == COL_W'(IMG_W - 1)) begin
          col_reg <= '0;
          row_reg <= (row_reg == ROW_W'(IMG_H - 1)) ? '0 : row_reg + 1'b1;
        end else begin
          col_reg <= col_reg + 1'b1;
        end
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
        out_last_reg  <= 1'b0;
      end

      if (accept) begin
        in_cnt_reg <= (in_cnt_reg == CNT_W'(NPIX - 1)) ? '0 : in_cnt_reg + 1'b1;
      end

      case (state_reg)
        FILL: begin
          if (accept && in_cnt_reg == CNT_W'(IMG_W + 1)) state_reg <= STREAM;
        end
        STREAM: begin
          if (accept && in_cnt_reg == CNT_W'(NPIX - 1)) state_reg <= FLUSH;
        end
        FLUSH: begin
          if (flush_emit && is_last_win) done_reg <= 1'b1;
          if (out_valid_reg && out_ready && out_last_reg) begin
            state_reg  <= FILL;
            done_reg   <= 1'b0;
            in_cnt_reg <= '0;
            col_reg    <= '0;
            row_reg    <= '0;
          end
        end
        default: state_reg <= FILL;
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign w0 = w_reg[0];
  assign w1 = w_reg[1];
  assign w2 = w_reg[2];
  assign w3 = w_reg[3];
  assign w4 = w_reg[TAP_CENTRE];
  assign w5 = w_reg[5];
  assign w6 = w_reg[6];
  assign w7 = w_reg[7];
  assign w8 = w_reg[8];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench for sobel_window_gen on a 4x3 image: fixed vectors,
// stalls, mid-frame reset and randomized back-to-back frames vs a padding model.
module tb_sobel_window_gen;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_pixel;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] w0, w1, w2, w3, w4, w5, w6, w7, w8;
  logic       out_last;

  sobel_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .TAP_W(9)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready),
    .w0(w0), .w1(w1), .w2(w2), .w3(w3), .w4(w4), .w5(w5), .w6(w6), .w7(w7), .w8(w8),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [80:0] taps;
    logic        last;
  } win_t;

  typedef struct {
    int          run;   // 0 = plain frame 1..12, 1 = frame after mid-frame reset
    int          k;
    logic [80:0] taps;
    logic        last;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [7:0]  stim [2*N];
  int          acc_cyc [2*N];
  win_t        got_q [$];
  win_t        run_a_q [$];
  win_t        run_r_q [$];
  int          last_cyc_q [$];
  int          first_valid_cyc = -1;
  logic [80:0] dut_taps;
  logic        prev_stall = 1'b0;
  logic [80:0] prev_taps;
  logic        prev_last;

  assign dut_taps = {w0, w1, w2, w3, w4, w5, w6, w7, w8};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [80:0] act, input logic [80:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: neighbourhood of pixel k taken straight from the frame, zero outside.
  function automatic logic [80:0] model_win(input int base, input int k);
    logic [80:0] v = '0;
    int r = k / W;
    int c = k % W;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        int rr = r + dr;
        int cc = c + dc;
        logic [8:0] t = '0;
        if (rr >= 0 && rr < H && cc >= 0 && cc < W) t = {1'b0, stim[base + rr*W + cc]};
        v = {v[71:0], t};
      end
    end
    return v;
  endfunction

  // Output monitor: logs transfers and checks hold-stability under backpressure.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_taps", dut_taps, prev_taps);
        check("hold_last", out_last, prev_last);
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        got_q.push_back('{taps: dut_taps, last: out_last});
        $display("[TB] window %0d taps=%h last=%0b", got_q.size() - 1, dut_taps, out_last);
        if (out_last) last_cyc_q.push_back(cyc + 1);
      end
      prev_stall = out_valid && !out_ready;
      prev_taps  = dut_taps;
      prev_last  = out_last;
    end
  end

  // mode 0: out_ready high; 1: 3-cycle stall once 7 pixels are in; 2: random out_ready.
  task automatic send(input int n, input int mode, input int n_win);
    int idx = 0;
    int guard = 0;
    int stall_left = 0;
    bit stalled = 0;
    bit chk_flush = 0;
    while ((idx < n || got_q.size() < n_win) && guard < 2000) begin
      in_valid = (idx < n);
      in_pixel = (idx < n) ? stim[idx] : 8'h00;
      if (mode == 1 && idx == 7 && !stalled) begin
        stall_left = 3;
        stalled = 1;
      end
      if (mode == 2) out_ready = ($urandom_range(0, 3) != 0);
      else           out_ready = (stall_left == 0);
      @(negedge clk);
      if (chk_flush) begin
        check("flush_in_ready", in_ready, 0);
        chk_flush = 0;
      end
      if (stall_left > 0) begin
        if (out_valid) check("stall_in_ready", in_ready, 0);
        stall_left--;
      end
      if (in_valid && in_ready) begin
        acc_cyc[idx] = cyc + 1;
        idx++;
        if (idx % N == 0) chk_flush = 1;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (guard >= 2000) check("send_timeout", 1, 0);
  endtask

  task automatic check_frame(input string tag, input int base, input int off);
    for (int k = 0; k < N; k++) begin
      if (off + k < got_q.size()) begin
        check($sformatf("%s_win%0d", tag, k), got_q[off + k].taps, model_win(base, k));
        check($sformatf("%s_last%0d", tag, k), got_q[off + k].last, (k == N - 1));
      end else begin
        check($sformatf("%s_missing%0d", tag, k), 0, 1);
      end
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{0, 0,  {9'd0, 9'd0, 9'd0, 9'd0, 9'd1, 9'd2, 9'd0, 9'd5, 9'd6}, 1'b0};
    vecs[1] = '{0, 5,  {9'd1, 9'd2, 9'd3, 9'd5, 9'd6, 9'd7, 9'd9, 9'd10, 9'd11}, 1'b0};
    vecs[2] = '{0, 7,  {9'd3, 9'd4, 9'd0, 9'd7, 9'd8, 9'd0, 9'd11, 9'd12, 9'd0}, 1'b0};
    vecs[3] = '{0, 11, {9'd7, 9'd8, 9'd0, 9'd11, 9'd12, 9'd0, 9'd0, 9'd0, 9'd0}, 1'b1};
    vecs[4] = '{1, 0,  {9'd0, 9'd0, 9'd0, 9'd0, 9'd101, 9'd102, 9'd0, 9'd105, 9'd106}, 1'b0};

    rst = 1'b1;
    in_valid = 1'b1;
    in_pixel = 8'hAA;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_last", out_last, 0);
    check("rst_taps", dut_taps, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;

    // Plain frame 1..12 with latency check on window 0.
    for (int i = 0; i < N; i++) stim[i] = 8'(i + 1);
    got_q.delete();
    first_valid_cyc = -1;
    send(N, 0, N);
    check("first_valid_latency", first_valid_cyc, acc_cyc[W + 1]);
    check("frameA_count", got_q.size(), N);
    check_frame("frameA", 0, 0);
    run_a_q = got_q;

    // Backpressure mid-stream must not change the window sequence.
    got_q.delete();
    send(N, 1, N);
    check("stall_count", got_q.size(), N);
    for (int k = 0; k < N && k < got_q.size(); k++)
      check($sformatf("stall_vs_nostall%0d", k), got_q[k].taps, run_a_q[k].taps);
    check_frame("stall", 0, 0);

    // Reset after 7 pixels, then a fresh frame 101..112.
    for (int i = 0; i < N; i++) stim[i] = 8'(i + 1);
    send(7, 0, 0);
    pulse_reset();
    got_q.delete();
    for (int i = 0; i < N; i++) stim[i] = 8'(101 + i);
    send(N, 0, N);
    check("rstframe_count", got_q.size(), N);
    check_frame("rstframe", 0, 0);
    run_r_q = got_q;

    // Table of hand-derived windows.
    for (int v = 0; v < 5; v++) begin
      win_t g;
      g = (vecs[v].run == 0) ? run_a_q[vecs[v].k] : run_r_q[vecs[v].k];
      check($sformatf("vec%0d_taps", v), g.taps, vecs[v].taps);
      check($sformatf("vec%0d_last", v), g.last, vecs[v].last);
    end

    // Two random frames back to back with random backpressure.
    for (int i = 0; i < 2*N; i++) stim[i] = 8'($urandom);
    got_q.delete();
    last_cyc_q.delete();
    send(2*N, 2, 2*N);
    check("b2b_count", got_q.size(), 2*N);
    check("b2b_last_count", last_cyc_q.size(), 2);
    check_frame("b2b_f1", 0, 0);
    check_frame("b2b_f2", N, N);
    if (last_cyc_q.size() > 0)
      check("b2b_gap", acc_cyc[N] > last_cyc_q[0], 1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
